unidade_controle: RTL

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 26 ++
 rtl/unidade_controle_op_decod.sv | 12 +
 rtl/unidade_controle.sv | 103 ++++++++++
 3 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the ALU control unit: opcodes, FSM states and instruction field layout.
// Pure declarations, no logic.
package unidade_controle_pkg;

  localparam int INSTR_W = 12;
  localparam int FIELD_W = 4;
  localparam int OP_MSB  = 11;
  localparam int A_MSB   = 7;
  localparam int B_MSB   = 3;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/unidade_controle_op_decod.sv
// Opcode legality check: ADD through DIV are legal, everything else is rejected.
// Purely combinational, zero latency, no flow control.
module op_decod
  import unidade_controle_pkg::*;
(
  input  logic [3:0] op,
  output logic       legal
);

  assign legal = (op >= OP_ADD) && (op <= OP_DIV);

endmodule

// File: rtl/unidade_controle.sv
// Sequences one instruction at a time to an external registered ALU and holds its result for a consumer.
// Result valid 3 cycles after accept (1 for illegal ops); res_ready low holds DONE and blocks new instructions.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int RES_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [OP_W-1:0]    op_ula,
  output logic [OP_W-1:0]    a_ula,
  output logic [OP_W-1:0]    b_ula,
  input  logic [RES_W-1:0]   out_ula,
  input  logic               sinal,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   res,
  output logic               res_sinal,
  output logic               res_err,
  output logic               busy,
  output logic [7:0]         n_exec
);

  state_t          state;
  logic [OP_W-1:0] op_in;
  logic [OP_W-1:0] a_in;
  logic [OP_W-1:0] b_in;
  logic            legal;

  assign op_in = instr[OP_MSB -: OP_W];
  assign a_in  = instr[A_MSB -: OP_W];
  assign b_in  = instr[B_MSB -: OP_W];

  op_decod u_op_decod (
    .op    (op_in),
    .legal (legal)
  );

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_ula    <= '0;
      a_ula     <= '0;
      b_ula     <= '0;
      res       <= '0;
      res_sinal <= 1'b0;
      res_err   <= 1'b0;
      n_exec    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            a_ula <= a_in;
            b_ula <= b_in;
            if (legal) begin
              op_ula <= op_in;
              state  <= EXEC;
            end else begin
              // Illegal ops never reach the ALU; the error result is ready immediately.
              op_ula    <= '0;
              res       <= '0;
              res_sinal <= 1'b0;
              res_err   <= 1'b1;
              state     <= DONE;
            end
          end
        end
        EXEC: begin
          state <= CAPT;
        end
        CAPT: begin
          res       <= out_ula;
          res_sinal <= sinal;
          res_err   <= 1'b0;
          op_ula    <= '0;
          a_ula     <= '0;
          b_ula     <= '0;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            // Operands of an illegal op are still latched here; clear them so IDLE drives zeros.
            n_exec <= n_exec + 8'd1;
            op_ula <= '0;
            a_ula  <= '0;
            b_ula  <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
